// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the EX-stage branch resolver: opcodes, FSM states, link register.
// Combinational helpers only; no latency, no flow control.
package branch_resolve_unit_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_BR   = 4'd1,
    OP_B    = 4'd2,
    OP_BL   = 4'd3,
    OP_BLTZ = 4'd4,
    OP_BZ   = 4'd5,
    OP_BNZ  = 4'd6,
    OP_BCY  = 4'd7,
    OP_BNCY = 4'd8
  } br_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } brs_state_e;

  localparam logic [4:0] LINK_REG_IDX = 5'd31;

  // Codes 9..15 are reserved and must behave as a plain non-branch.
  function automatic br_op_e decode_br_op(input logic [3:0] raw);
    if (raw > 4'd8) begin
      return OP_NONE;
    end
    return br_op_e'(raw);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition and target evaluation for one EX-stage instruction.
// Purely combinational (0 cycles); no flow control.
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
#(
  parameter int OFFSET_W = 22
) (
  input  logic [3:0]          br_op,
  input  logic [31:0]         pc_in,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [31:0]         rs_val,
  input  logic                carry_q,
  output logic                taken,
  output logic                is_link,
  output logic [31:0]         target
);

  br_op_e      op;
  logic [31:0] off_ext;

  assign op      = decode_br_op(br_op);
  assign off_ext = 32'($signed(offset));

  always_comb begin
    taken   = 1'b0;
    is_link = 1'b0;
    // Label branches wrap silently modulo 2^32.
    target  = pc_in + off_ext;
    case (op)
      OP_BR: begin
        taken  = 1'b1;
        target = rs_val;
      end
      OP_B:    taken = 1'b1;
      OP_BL: begin
        taken   = 1'b1;
        is_link = 1'b1;
      end
      OP_BLTZ: taken = rs_val[31];
      OP_BZ:   taken = (rs_val == 32'd0);
      OP_BNZ:  taken = (rs_val != 32'd0);
      OP_BCY:  taken = carry_q;
      OP_BNCY: taken = ~carry_q;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage branches, redirects the PC, writes the link register and squashes wrong-path fetches.
// Latency 1 cycle; no backpressure: instructions arriving while flushing are dropped.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int OFFSET_W    = 22,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic [3:0]          br_op,
  input  logic [31:0]         pc_in,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [31:0]         rs_val,
  input  logic                flag_we,
  input  logic                alu_carry,
  output logic                PCSrc,
  output logic [31:0]         exNPC,
  output logic                link_we,
  output logic [31:0]         link_data,
  output logic                flush
);

  localparam int CNT_W = (FLUSH_DEPTH < 1) ? 1 : $clog2(FLUSH_DEPTH + 1);

  brs_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic        pcsrc_q, pcsrc_d;
  logic [31:0] exnpc_q, exnpc_d;
  logic        link_we_q, link_we_d;
  logic [31:0] link_data_q, link_data_d;
  logic        flush_q, flush_d;

  logic        cond_taken;
  logic        cond_link;
  logic [31:0] cond_target;

  branch_cond_eval #(
    .OFFSET_W (OFFSET_W)
  ) u_cond (
    .br_op   (br_op),
    .pc_in   (pc_in),
    .offset  (offset),
    .rs_val  (rs_val),
    .carry_q (carry_q),
    .taken   (cond_taken),
    .is_link (cond_link),
    .target  (cond_target)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pcsrc_d     = 1'b0;
    exnpc_d     = exnpc_q;
    link_we_d   = 1'b0;
    link_data_d = link_data_q;
    // The flag updates regardless of FSM state; branches see the pre-edge value.
    carry_d     = flag_we ? alu_carry : carry_q;

    case (state_q)
      ST_IDLE: begin
        if (valid && cond_taken) begin
          pcsrc_d = 1'b1;
          exnpc_d = cond_target;
          if (cond_link) begin
            link_we_d   = 1'b1;
            link_data_d = pc_in + 32'd1;
          end
          if (FLUSH_DEPTH > 0) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_W'(FLUSH_DEPTH);
          end
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    flush_d = (state_d == ST_FLUSH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      pcsrc_q     <= 1'b0;
      exnpc_q     <= 32'd0;
      link_we_q   <= 1'b0;
      link_data_q <= 32'd0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      pcsrc_q     <= pcsrc_d;
      exnpc_q     <= exnpc_d;
      link_we_q   <= link_we_d;
      link_data_q <= link_data_d;
      flush_q     <= flush_d;
    end
  end

  assign PCSrc     = pcsrc_q;
  assign exNPC     = exnpc_q;
  assign link_we   = link_we_q;
  assign link_data = link_data_q;
  assign flush     = flush_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic against a countdown model.
module tb_branch_resolve_unit;

  localparam int OFFSET_W    = 22;
  localparam int FLUSH_DEPTH = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                valid = 1'b0;
  logic [3:0]          br_op = 4'd0;
  logic [31:0]         pc_in = 32'd0;
  logic [OFFSET_W-1:0] offset = '0;
  logic [31:0]         rs_val = 32'd0;
  logic                flag_we = 1'b0;
  logic                alu_carry = 1'b0;
  logic                PCSrc;
  logic [31:0]         exNPC;
  logic                link_we;
  logic [31:0]         link_data;
  logic                flush;

  branch_resolve_unit #(
    .OFFSET_W    (OFFSET_W),
    .FLUSH_DEPTH (FLUSH_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .br_op     (br_op),
    .pc_in     (pc_in),
    .offset    (offset),
    .rs_val    (rs_val),
    .flag_we   (flag_we),
    .alu_carry (alu_carry),
    .PCSrc     (PCSrc),
    .exNPC     (exNPC),
    .link_we   (link_we),
    .link_data (link_data),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: cycles of squash remaining plus the architecturally visible outputs.
  int          m_left  = 0;
  logic        m_carry = 1'b0;
  logic        e_pcsrc = 1'b0;
  logic [31:0] e_npc   = 32'd0;
  logic        e_lwe   = 1'b0;
  logic [31:0] e_ldata = 32'd0;
  logic        e_flush = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left  = 0;
    m_carry = 1'b0;
    e_pcsrc = 1'b0;
    e_npc   = 32'd0;
    e_lwe   = 1'b0;
    e_ldata = 32'd0;
    e_flush = 1'b0;
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".pcsrc"},     32'(PCSrc),   32'(e_pcsrc));
    chk({where, ".exnpc"},     exNPC,        e_npc);
    chk({where, ".link_we"},   32'(link_we), 32'(e_lwe));
    chk({where, ".link_data"}, link_data,    e_ldata);
    chk({where, ".flush"},     32'(flush),   32'(e_flush));
  endtask

  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] pc,
                      input logic [OFFSET_W-1:0] off, input logic [31:0] rs,
                      input logic fwe, input logic cy);
    int          off_i;
    logic        tk;
    logic [31:0] tgt;
    @(negedge clk);
    valid = v; br_op = op; pc_in = pc; offset = off; rs_val = rs;
    flag_we = fwe; alu_carry = cy;

    off_i   = $signed(off);
    tgt     = pc + 32'(off_i);
    tk      = 1'b0;
    e_pcsrc = 1'b0;
    e_lwe   = 1'b0;
    if (m_left > 0) begin
      m_left = m_left - 1;
    end else if (v) begin
      case (op)
        4'd1: begin tk = 1'b1; tgt = rs; end
        4'd2, 4'd3: tk = 1'b1;
        4'd4: tk = rs[31];
        4'd5: tk = (rs == 32'd0);
        4'd6: tk = (rs != 32'd0);
        4'd7: tk = m_carry;
        4'd8: tk = !m_carry;
        default: tk = 1'b0;
      endcase
      if (tk) begin
        e_pcsrc = 1'b1;
        e_npc   = tgt;
        m_left  = FLUSH_DEPTH;
        if (op == 4'd3) begin
          e_lwe   = 1'b1;
          e_ldata = pc + 32'd1;
        end
      end
    end
    e_flush = (m_left > 0);
    if (fwe) m_carry = cy;

    @(posedge clk);
    #1;
    check_outputs("step");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, '0, 32'd0, 1'b0, 1'b0);
  endtask

  // Reset pulse placed mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic reset_pulse();
    @(negedge clk);
    #2;
    valid = 1'b1; br_op = 4'd2; flag_we = 1'b1; alu_carry = 1'b1;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("rst_async");
    @(posedge clk);
    #1;
    check_outputs("rst_hold");
    @(negedge clk);
    valid = 1'b0; flag_we = 1'b0; alu_carry = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] rs;
    #1;
    model_reset();
    check_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    check_outputs("por_clk");
    @(negedge clk);
    reset = 1'b0;

    // B at 0x10, offset -4
    step(1'b1, 4'd2, 32'h10, 22'h3FFFFC, 32'd0, 1'b0, 1'b0);
    chk("b_back.pcsrc", 32'(PCSrc), 32'd1);
    chk("b_back.exnpc", exNPC, 32'h0000_000C);
    chk("b_back.flush1", 32'(flush), 32'd1);
    idle(1);
    chk("b_back.flush2", 32'(flush), 32'd1);
    chk("b_back.pcsrc_off", 32'(PCSrc), 32'd0);
    idle(1);
    chk("b_back.flush_end", 32'(flush), 32'd0);

    // BL at 0x20, offset 0x100
    step(1'b1, 4'd3, 32'h20, 22'h100, 32'd0, 1'b0, 1'b0);
    chk("bl.exnpc", exNPC, 32'h120);
    chk("bl.link_we", 32'(link_we), 32'd1);
    chk("bl.link_data", link_data, 32'h21);
    idle(1);
    chk("bl.link_we_off", 32'(link_we), 32'd0);
    idle(1);

    // BZ / BLTZ
    step(1'b1, 4'd5, 32'h40, 22'h8, 32'd0, 1'b0, 1'b0);
    chk("bz0.pcsrc", 32'(PCSrc), 32'd1);
    idle(2);
    step(1'b1, 4'd5, 32'h40, 22'h8, 32'd5, 1'b0, 1'b0);
    chk("bz5.pcsrc", 32'(PCSrc), 32'd0);
    chk("bz5.flush", 32'(flush), 32'd0);
    step(1'b1, 4'd4, 32'h50, 22'h4, 32'h8000_0000, 1'b0, 1'b0);
    chk("bltz.pcsrc", 32'(PCSrc), 32'd1);
    idle(2);

    // Carry write on the same edge as BCY is not bypassed
    step(1'b1, 4'd7, 32'h60, 22'h10, 32'd0, 1'b1, 1'b1);
    chk("bcy_same.pcsrc", 32'(PCSrc), 32'd0);
    step(1'b1, 4'd7, 32'h60, 22'h10, 32'd0, 1'b0, 1'b0);
    chk("bcy_next.pcsrc", 32'(PCSrc), 32'd1);
    chk("bcy_next.exnpc", exNPC, 32'h70);
    idle(2);

    // Wrap-around target and register-indirect target
    step(1'b1, 4'd2, 32'hFFFF_FFFF, 22'h2, 32'd0, 1'b0, 1'b0);
    chk("wrap.exnpc", exNPC, 32'h0000_0001);
    idle(2);
    step(1'b1, 4'd1, 32'h80, 22'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("br.exnpc", exNPC, 32'hDEAD_BEEF);
    idle(2);

    // Second branch during flush is dropped
    step(1'b1, 4'd2, 32'h100, 22'h4, 32'd0, 1'b0, 1'b0);
    step(1'b1, 4'd1, 32'h104, 22'h0, 32'h1234, 1'b0, 1'b0);
    chk("squash.pcsrc", 32'(PCSrc), 32'd0);
    chk("squash.exnpc", exNPC, 32'h104);
    idle(1);

    // Reset in the middle of a flush, then a fresh branch is accepted at once
    step(1'b1, 4'd3, 32'h200, 22'h8, 32'd0, 1'b0, 1'b0);
    reset_pulse();
    chk("rst_mid.flush", 32'(flush), 32'd0);
    step(1'b1, 4'd8, 32'h300, 22'h3FFFF0, 32'd0, 1'b0, 1'b0);
    chk("post_rst.pcsrc", 32'(PCSrc), 32'd1);
    chk("post_rst.exnpc", exNPC, 32'h2F0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_pulse();
      end else begin
        case ($urandom_range(0, 3))
          0: rs = 32'd0;
          1: rs = 32'h8000_0000 | $urandom;
          default: rs = $urandom;
        endcase
        step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom,
             OFFSET_W'($urandom), rs, 1'($urandom), 1'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
